// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: load/store selectors,
// FSM state encoding, access size, and small alignment helpers.
package lsu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] DRAM_RD_NONE = 3'd0;
    localparam logic [2:0] DRAM_RD_B    = 3'd1;
    localparam logic [2:0] DRAM_RD_H    = 3'd2;
    localparam logic [2:0] DRAM_RD_W    = 3'd3;
    localparam logic [2:0] DRAM_RD_BU   = 3'd4;
    localparam logic [2:0] DRAM_RD_HU   = 3'd5;

    localparam logic [1:0] DRAM_WR_NONE = 2'd0;
    localparam logic [1:0] DRAM_WR_B    = 2'd1;
    localparam logic [1:0] DRAM_WR_H    = 2'd2;
    localparam logic [1:0] DRAM_WR_W    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Unused load encodings fall back to a full word access.
    function automatic lsu_size_t rd_size(input logic [2:0] sel);
        case (sel)
            DRAM_RD_B, DRAM_RD_BU: rd_size = SZ_B;
            DRAM_RD_H, DRAM_RD_HU: rd_size = SZ_H;
            default:               rd_size = SZ_W;
        endcase
    endfunction

    function automatic lsu_size_t wr_size(input logic [1:0] sel);
        case (sel)
            DRAM_WR_B: wr_size = SZ_B;
            DRAM_WR_H: wr_size = SZ_H;
            default:   wr_size = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    is_misaligned = lo[0];
            SZ_W:    is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input lsu_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    force_align = {lo[1], 1'b0};
            SZ_W:    force_align = 2'b00;
            default: force_align = lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// DRAM-side request/response bus of the load/store unit.
// master = LSU (drives request), slave = memory (drives grant/read data).
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            dram_req_o;
    logic            dram_we_o;
    logic [XLEN-1:0] dram_addr_o;
    logic [3:0]      dram_be_o;
    logic [XLEN-1:0] dram_wr_data_o;
    logic            dram_gnt_i;
    logic            dram_rvalid_i;
    logic [XLEN-1:0] dram_rdata_i;

    modport master (
        output dram_req_o,
        output dram_we_o,
        output dram_addr_o,
        output dram_be_o,
        output dram_wr_data_o,
        input  dram_gnt_i,
        input  dram_rvalid_i,
        input  dram_rdata_i
    );

    modport slave (
        input  dram_req_o,
        input  dram_we_o,
        input  dram_addr_o,
        input  dram_be_o,
        input  dram_wr_data_o,
        output dram_gnt_i,
        output dram_rvalid_i,
        output dram_rdata_i
    );
endinterface

// File: rtl/lsu_align.sv
// Lane logic: byte enables, store data replication and load data shifting.
// Purely combinational; zero latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_size_t       size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [XLEN-1:0] rd_data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be_o      = 4'b1111;
        wr_data_o = wr_data_i;
        rd_data_o = rdata_i;
        shifted   = rdata_i;
        case (size_i)
            SZ_B: begin
                be_o      = 4'b0001 << addr_lo_i;
                wr_data_o = {4{wr_data_i[7:0]}};
                shifted   = rdata_i >> {addr_lo_i, 3'b000};
                rd_data_o = {24'b0, shifted[7:0]};
            end
            SZ_H: begin
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                wr_data_o = {2{wr_data_i[15:0]}};
                shifted   = rdata_i >> {addr_lo_i[1], 4'b0000};
                rd_data_o = {16'b0, shifted[15:0]};
            end
            default: begin
                be_o      = 4'b1111;
                wr_data_o = wr_data_i;
                rd_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding DRAM access, FSM IDLE->REQ->(WAIT)->DONE.
// Latency: store 2 cycles, load 3 cycles minimum; stall_o holds EX while busy.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of realigning.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [2:0]      rd_sel_i,
    input  logic [1:0]      wr_sel_i,
    output logic            stall_o,
    lsu_if.master           dram,
    output logic [2:0]      dram_rd_sel_o,
    output logic [XLEN-1:0] dram_rd_data_o,
    output logic            done_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    lsu_state_t      state_q,  state_d;
    logic [XLEN-1:0] addr_q,   addr_d;
    logic [XLEN-1:0] wdata_q,  wdata_d;
    logic [XLEN-1:0] rdata_q,  rdata_d;
    logic [2:0]      rd_sel_q, rd_sel_d;
    logic            load_q,   load_d;
    lsu_size_t       size_q,   size_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    logic            is_load;
    logic            start;
    lsu_size_t       size_in;
    logic [3:0]      be_w;
    logic [XLEN-1:0] wr_rep_w;
    logic [XLEN-1:0] rd_shift_w;

    // A load wins when both selectors are set; the store half is dropped.
    assign is_load = (rd_sel_i != DRAM_RD_NONE);
    assign start   = req_i && (is_load || (wr_sel_i != DRAM_WR_NONE));
    assign size_in = is_load ? rd_size(rd_sel_i) : wr_size(wr_sel_i);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_sel_d = rd_sel_q;
        load_d   = load_q;
        size_d   = size_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = {addr_i[XLEN-1:2], force_align(size_in, addr_i[1:0])};
                    wdata_d  = wr_data_i;
                    load_d   = is_load;
                    size_d   = size_in;
                    rd_sel_d = is_load ? rd_sel_i : DRAM_RD_NONE;
                    state_d  = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(size_in, addr_i[1:0])) begin
                        misalign_d = 1'b1;
                        rd_sel_d   = DRAM_RD_NONE;
                        state_d    = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (dram.dram_gnt_i) begin
                    state_d = load_q ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (dram.dram_rvalid_i) begin
                    rdata_d = dram.dram_rdata_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_sel_q <= DRAM_RD_NONE;
            load_q   <= 1'b0;
            size_q   <= SZ_B;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_sel_q <= rd_sel_d;
            load_q   <= load_d;
            size_q   <= size_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wr_data_i (wdata_q),
        .rdata_i   (rdata_q),
        .be_o      (be_w),
        .wr_data_o (wr_rep_w),
        .rd_data_o (rd_shift_w)
    );

    // Bus outputs are driven straight from state so reset drops them at once.
    always_comb begin
        dram.dram_req_o     = (state_q == REQ);
        dram.dram_we_o      = (state_q == REQ) && !load_q;
        dram.dram_addr_o    = (state_q == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
        dram.dram_be_o      = (state_q == REQ) ? be_w : 4'b0000;
        dram.dram_wr_data_o = (state_q == REQ) ? wr_rep_w : '0;
    end

    assign done_o         = (state_q == DONE);
    assign dram_rd_sel_o  = (state_q == DONE) ? rd_sel_q : DRAM_RD_NONE;
    assign dram_rd_data_o = ((state_q == DONE) && (rd_sel_q != DRAM_RD_NONE)) ? rd_shift_w : '0;
    assign stall_o        = ((state_q == IDLE) && start) || (state_q == REQ) || (state_q == WAIT);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o     = (state_q == DONE) && misalign_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; drives the DRAM slave side by hand.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic [2:0]  rd_sel_i;
    logic [1:0]  wr_sel_i;
    logic        stall_o;
    logic [2:0]  dram_rd_sel_o;
    logic [31:0] dram_rd_data_o;
    logic        done_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int done_cnt;

    lsu_if #(.XLEN(32)) bus ();

    always #5 clk_i = ~clk_i;

    lsu #(.XLEN(32)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_i          (req_i),
        .addr_i         (addr_i),
        .wr_data_i      (wr_data_i),
        .rd_sel_i       (rd_sel_i),
        .wr_sel_i       (wr_sel_i),
        .stall_o        (stall_o),
        .dram           (bus.master),
        .dram_rd_sel_o  (dram_rd_sel_o),
        .dram_rd_data_o (dram_rd_data_o),
        .done_o         (done_o)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        req_i             = 1'b0;
        addr_i            = '0;
        wr_data_i         = '0;
        rd_sel_i          = DRAM_RD_NONE;
        wr_sel_i          = DRAM_WR_NONE;
        bus.dram_gnt_i    = 1'b0;
        bus.dram_rvalid_i = 1'b0;
        bus.dram_rdata_i  = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n_i = 1'b0;
        #12;
        n_run++;
        if ({stall_o, bus.dram_req_o, bus.dram_we_o, bus.dram_addr_o, bus.dram_be_o,
             bus.dram_wr_data_o, dram_rd_sel_o, dram_rd_data_o, done_o} !== 107'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wd=%h sel=%0d rd=%h done=%b stall=%b, need all 0",
                     bus.dram_req_o, bus.dram_we_o, bus.dram_addr_o, bus.dram_be_o, bus.dram_wr_data_o,
                     dram_rd_sel_o, dram_rd_data_o, done_o, stall_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_load_byte;
        req_i = 1'b1; addr_i = 32'h0000_1003; rd_sel_i = DRAM_RD_B;
        bus.dram_gnt_i = 1'b1; bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'hAABB_CCDD;
        @(negedge clk_i);
        n_run++;
        if ({stall_o, bus.dram_req_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL lb_issue: stall,req=%b need 10", {stall_o, bus.dram_req_o});
        end
        step(); req_i = 1'b0;
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, stall_o} !== {1'b1, 1'b0, 4'b1000, 32'h0000_1000, 1'b1}) begin
            n_fail++;
            $display("FAIL lb_req: req=%b we=%b be=%b addr=%h stall=%b need 1 0 1000 00001000 1",
                     bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, stall_o);
        end
        step();
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, stall_o, done_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL lb_wait: req,stall,done=%b need 010", {bus.dram_req_o, stall_o, done_o});
        end
        step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o, stall_o} !== {1'b1, DRAM_RD_B, 32'h0000_00AA, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_done: done=%b sel=%0d data=%h stall=%b need 1 1 000000aa 0",
                     done_o, dram_rd_sel_o, dram_rd_data_o, stall_o);
        end
        idle_inputs();
        step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o} !== 36'b0) begin
            n_fail++;
            $display("FAIL lb_after: done=%b sel=%0d data=%h need 0 0 0", done_o, dram_rd_sel_o, dram_rd_data_o);
        end
    endtask

    task automatic test_store_half;
        step();
        req_i = 1'b1; addr_i = 32'h0000_2002; wr_data_i = 32'h1234_5678; wr_sel_i = DRAM_WR_H;
        step(); req_i = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.dram_gnt_i = 1'b1;
            @(negedge clk_i);
            if (done_o) done_cnt++;
            n_run++;
            if ({bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, bus.dram_wr_data_o, stall_o}
                !== {1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'h5678_5678, 1'b1}) begin
                n_fail++;
                $display("FAIL sh_hold[%0d]: req=%b we=%b be=%b addr=%h wd=%h stall=%b need 1 1 1100 00002000 56785678 1",
                         i, bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, bus.dram_wr_data_o, stall_o);
            end
            step();
        end
        bus.dram_gnt_i = 1'b0;
        @(negedge clk_i);
        if (done_o) done_cnt++;
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o, stall_o, bus.dram_req_o} !== {1'b1, DRAM_RD_NONE, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sh_done: done=%b sel=%0d data=%h stall=%b req=%b need 1 0 0 0 0",
                     done_o, dram_rd_sel_o, dram_rd_data_o, stall_o, bus.dram_req_o);
        end
        idle_inputs();
        step();
        @(negedge clk_i);
        if (done_o) done_cnt++;
        n_run++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL sh_done_count: got %0d pulses need 1", done_cnt);
        end
    endtask

    task automatic test_load_word_wait;
        bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'hDEAD_BEEF;
        step(); step();
        n_run++;
        if ({stall_o, done_o, bus.dram_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL lw_spurious_idle: stall,done,req=%b need 000", {stall_o, done_o, bus.dram_req_o});
        end
        bus.dram_rvalid_i = 1'b0;
        req_i = 1'b1; addr_i = 32'h0000_4000; rd_sel_i = DRAM_RD_W;
        step(); req_i = 1'b0; bus.dram_gnt_i = 1'b1;
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o} !== {1'b1, 1'b0, 4'b1111, 32'h0000_4000}) begin
            n_fail++;
            $display("FAIL lw_req: req=%b we=%b be=%b addr=%h need 1 0 1111 00004000",
                     bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o);
        end
        step(); bus.dram_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_run++;
            if ({bus.dram_req_o, stall_o, done_o, dram_rd_data_o} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL lw_wait[%0d]: req=%b stall=%b done=%b data=%h need 0 1 0 0",
                         i, bus.dram_req_o, stall_o, done_o, dram_rd_data_o);
            end
            step();
        end
        bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'hCAFE_F00D;
        step();
        bus.dram_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o} !== {1'b1, DRAM_RD_W, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL lw_done: done=%b sel=%0d data=%h need 1 3 cafef00d", done_o, dram_rd_sel_o, dram_rd_data_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid;
        req_i = 1'b1; addr_i = 32'h0000_8000; rd_sel_i = DRAM_RD_W;
        step(); req_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        n_run++;
        if ({bus.dram_req_o, stall_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_in_req: req,stall=%b need 00", {bus.dram_req_o, stall_o});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        req_i = 1'b1; bus.dram_gnt_i = 1'b1;
        step(); req_i = 1'b0;
        step(); bus.dram_gnt_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        n_run++;
        if ({bus.dram_req_o, stall_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_in_wait: req,stall,done=%b need 000", {bus.dram_req_o, stall_o, done_o});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'h5555_AAAA;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk_i);
            if (done_o || stall_o || (dram_rd_data_o != 32'h0)) done_cnt++;
        end
        n_run++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_late_rvalid: %0d cycles showed activity, need 0", done_cnt);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_misalign;
        req_i = 1'b1; addr_i = 32'h0000_3001; rd_sel_i = DRAM_RD_H;
        bus.dram_gnt_i = 1'b1; bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'h1122_3344;
        step(); req_i = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk_i);
        n_run++;
        if ({done_o, misalign_o, bus.dram_req_o, dram_rd_sel_o, dram_rd_data_o} !== {1'b1, 1'b1, 1'b0, DRAM_RD_NONE, 32'h0}) begin
            n_fail++;
            $display("FAIL lh_trap: done=%b mis=%b req=%b sel=%0d data=%h need 1 1 0 0 0",
                     done_o, misalign_o, bus.dram_req_o, dram_rd_sel_o, dram_rd_data_o);
        end
        step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, misalign_o, bus.dram_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL lh_trap_after: done,mis,req=%b need 000", {done_o, misalign_o, bus.dram_req_o});
        end
`else
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, bus.dram_be_o, bus.dram_addr_o} !== {1'b1, 4'b0011, 32'h0000_3000}) begin
            n_fail++;
            $display("FAIL lh_realign: req=%b be=%b addr=%h need 1 0011 00003000",
                     bus.dram_req_o, bus.dram_be_o, bus.dram_addr_o);
        end
        step(); step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o} !== {1'b1, DRAM_RD_H, 32'h0000_3344}) begin
            n_fail++;
            $display("FAIL lh_realign_done: done=%b sel=%0d data=%h need 1 2 00003344",
                     done_o, dram_rd_sel_o, dram_rd_data_o);
        end
`endif
        idle_inputs();
        step();
    endtask

    task automatic test_load_store_conflict;
        req_i = 1'b1; addr_i = 32'h0000_5002; rd_sel_i = DRAM_RD_BU; wr_sel_i = DRAM_WR_W;
        wr_data_i = 32'hFFFF_FFFF;
        bus.dram_gnt_i = 1'b1; bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'h1122_3344;
        step(); req_i = 1'b0;
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o} !== {1'b1, 1'b0, 4'b0100, 32'h0000_5000}) begin
            n_fail++;
            $display("FAIL conflict_req: req=%b we=%b be=%b addr=%h need 1 0 0100 00005000",
                     bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o);
        end
        step(); step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o} !== {1'b1, DRAM_RD_BU, 32'h0000_0022}) begin
            n_fail++;
            $display("FAIL conflict_done: done=%b sel=%0d data=%h need 1 4 00000022",
                     done_o, dram_rd_sel_o, dram_rd_data_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back;
        req_i = 1'b1; addr_i = 32'h0000_6001; wr_sel_i = DRAM_WR_B; wr_data_i = 32'h0000_00A5;
        bus.dram_gnt_i = 1'b1; bus.dram_rvalid_i = 1'b1; bus.dram_rdata_i = 32'h8899_AABB;
        step(); req_i = 1'b0;
        @(negedge clk_i);
        n_run++;
        if ({bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, bus.dram_wr_data_o}
            !== {1'b1, 1'b1, 4'b0010, 32'h0000_6000, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL sb_req: req=%b we=%b be=%b addr=%h wd=%h need 1 1 0010 00006000 a5a5a5a5",
                     bus.dram_req_o, bus.dram_we_o, bus.dram_be_o, bus.dram_addr_o, bus.dram_wr_data_o);
        end
        step();
        // Request already presented during DONE must not start until IDLE.
        req_i = 1'b1; addr_i = 32'h0000_7002; wr_sel_i = DRAM_WR_NONE; rd_sel_i = DRAM_RD_HU;
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, stall_o} !== {1'b1, DRAM_RD_NONE, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_done: done=%b sel=%0d stall=%b need 1 0 0", done_o, dram_rd_sel_o, stall_o);
        end
        step();
        @(negedge clk_i);
        n_run++;
        if ({stall_o, bus.dram_req_o, done_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_idle_start: stall,req,done=%b need 100", {stall_o, bus.dram_req_o, done_o});
        end
        step(); req_i = 1'b0;
        step(); step();
        @(negedge clk_i);
        n_run++;
        if ({done_o, dram_rd_sel_o, dram_rd_data_o} !== {1'b1, DRAM_RD_HU, 32'h0000_8899}) begin
            n_fail++;
            $display("FAIL lhu_done: done=%b sel=%0d data=%h need 1 5 00008899",
                     done_o, dram_rd_sel_o, dram_rd_data_o);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_load_word_wait();
        test_reset_mid();
        test_misalign();
        test_load_store_conflict();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
